// File: rtl/srambank_pkg.sv
// Shared types and helpers for the srambank array.
//   op_e        : per-cycle operation decoded from banksel/read/write
//   clog2_safe  : ceil(log2(value)), returning 0 for a value of 1
//   read_lat_ok : legal read latencies (1 or 2)
//   decode_op   : banksel/read/write -> op_e (a write wins over a read)
package srambank_pkg;

  typedef enum logic [1:0] {
    OP_IDLE,
    OP_READ,
    OP_WRITE,
    OP_CONFLICT
  } op_e;

  function automatic int unsigned clog2_safe(input int unsigned value);
    int unsigned w;
    w = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) w = i + 1;
    end
    return w;
  endfunction

  function automatic logic read_lat_ok(input int unsigned lat);
    return (lat == 1) || (lat == 2);
  endfunction

  function automatic op_e decode_op(input logic banksel, input logic read, input logic write);
    op_e op;
    op = OP_IDLE;
    if (banksel) begin
      if (write && read) op = OP_CONFLICT;
      else if (write)    op = OP_WRITE;
      else if (read)     op = OP_READ;
    end
    return op;
  endfunction

endpackage

// File: rtl/srambank_core.sv
// One DEPTH x WIDTH single-port bank with lane write mask and a registered
// read port.
//   clk   : clock
//   en    : bank enable; nothing happens when low
//   we    : write when high, read when low (only while en is high)
//   addr  : row address
//   wd    : write data
//   wmask : lane i enables bits [i*LANE +: LANE]
//   rdata : registered read data; updates only on an enabled read
module srambank_core
  import srambank_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 128,
  parameter int unsigned LANE  = 4
) (
  input  logic                                clk,
  input  logic                                en,
  input  logic                                we,
  input  logic [clog2_safe(DEPTH)-1:0]        addr,
  input  logic [WIDTH-1:0]                    wd,
  input  logic [WIDTH/LANE-1:0]               wmask,
  output logic [WIDTH-1:0]                    rdata
);

  localparam int unsigned NL = WIDTH / LANE;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // Macro-style array: contents and read register are not reset.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int unsigned i = 0; i < NL; i++) begin
          if (wmask[i]) mem[addr][i*LANE +: LANE] <= wd[i*LANE +: LANE];
        end
      end else begin
        rdata_q <= mem[addr];
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/srambank_array.sv
// Single-port SRAM array of NBANKS srambank_core banks.
//   clk      : clock
//   reset    : asynchronous active-high; clears pipeline/outputs, not contents
//   ADDRESS  : [AW-1:RW] bank, [RW-1:0] row
//   wd       : write data
//   wmask    : per-lane write enable
//   banksel  : global access enable
//   read     : read request
//   write    : write request (wins over read)
//   dataout  : read data, holds until the next completed read
//   rvalid   : one-cycle strobe with each dataout update
//   conflict : high for one cycle after a read&write request
module srambank_array
  import srambank_pkg::*;
#(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned DEPTH    = 128,
  parameter int unsigned NBANKS   = 4,
  parameter int unsigned LANE     = 4,
  parameter int unsigned READ_LAT = 1
) (
  input  logic                                                clk,
  input  logic                                                reset,
  input  logic [clog2_safe(DEPTH)+clog2_safe(NBANKS)-1:0]     ADDRESS,
  input  logic [WIDTH-1:0]                                    wd,
  input  logic [WIDTH/LANE-1:0]                               wmask,
  input  logic                                                banksel,
  input  logic                                                read,
  input  logic                                                write,
  output logic [WIDTH-1:0]                                    dataout,
  output logic                                                rvalid,
  output logic                                                conflict
);

  localparam int unsigned RW  = clog2_safe(DEPTH);
  localparam int unsigned BW  = clog2_safe(NBANKS);
  localparam int unsigned AW  = RW + BW;
  localparam int unsigned BWS = (BW == 0) ? 1 : BW;

  if (!read_lat_ok(READ_LAT)) begin : g_bad_read_lat
    $error("srambank_array: READ_LAT must be 1 or 2");
  end

  op_e              op;
  logic             is_rd;
  logic             is_wr;
  logic [BWS-1:0]   addr_bank;
  logic [WIDTH-1:0] core_rdata [NBANKS];
  logic [WIDTH-1:0] rd_mux;

  logic             s1_valid_q, s1_valid_d;
  logic [BWS-1:0]   bank_q, bank_d;
  logic             conflict_q, conflict_d;

  if (NBANKS > 1) begin : g_bank_idx
    assign addr_bank = ADDRESS[AW-1:RW];
  end else begin : g_single_bank
    assign addr_bank = '0;
  end

  always_comb begin
    op         = decode_op(banksel, read, write);
    is_rd      = (op == OP_READ);
    is_wr      = (op == OP_WRITE) || (op == OP_CONFLICT);
    s1_valid_d = is_rd;
    bank_d     = is_rd ? addr_bank : bank_q;
    conflict_d = (op == OP_CONFLICT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      bank_q     <= '0;
      conflict_q <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      bank_q     <= bank_d;
      conflict_q <= conflict_d;
    end
  end

  for (genvar b = 0; b < NBANKS; b++) begin : g_bank
    logic hit;
    assign hit = (addr_bank == BWS'(b));

    srambank_core #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .LANE  (LANE)
    ) u_core (
      .clk   (clk),
      .en    (hit & (is_rd | is_wr)),
      .we    (is_wr),
      .addr  (ADDRESS[RW-1:0]),
      .wd    (wd),
      .wmask (wmask),
      .rdata (core_rdata[b])
    );
  end

  // Each core's read register only moves on a read of that bank, and bank_q
  // only moves on a read, so this mux holds the last read word between reads.
  assign rd_mux   = core_rdata[bank_q];
  assign conflict = conflict_q;

  if (READ_LAT == 1) begin : g_lat1
    // The core read register is the output stage; seen_q masks its
    // unreset contents until the first read after reset.
    logic seen_q, seen_d;

    always_comb seen_d = seen_q | s1_valid_d;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) seen_q <= 1'b0;
      else       seen_q <= seen_d;
    end

    assign dataout = seen_q ? rd_mux : '0;
    assign rvalid  = s1_valid_q;
  end else begin : g_lat2
    logic [WIDTH-1:0] dataout_q, dataout_d;
    logic             rvalid_q, rvalid_d;

    always_comb begin
      dataout_d = s1_valid_q ? rd_mux : dataout_q;
      rvalid_d  = s1_valid_q;
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        dataout_q <= '0;
        rvalid_q  <= 1'b0;
      end else begin
        dataout_q <= dataout_d;
        rvalid_q  <= rvalid_d;
      end
    end

    assign dataout = dataout_q;
    assign rvalid  = rvalid_q;
  end

endmodule

// File: tb/tb_srambank_array.sv
module tb_srambank_array;

  localparam int unsigned LANE = 4;
  localparam int unsigned NL   = 4;

  logic        clk   = 1'b0;
  logic        reset = 1'b0;
  logic [8:0]  ADDRESS = '0;
  logic [15:0] wd      = '0;
  logic [3:0]  wmask   = '0;
  logic        banksel = 1'b0;
  logic        read    = 1'b0;
  logic        write   = 1'b0;

  logic [15:0] dout1, dout2;
  logic        rv1, rv2, cf1, cf2;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  srambank_array #(
    .WIDTH    (16),
    .DEPTH    (128),
    .NBANKS   (4),
    .LANE     (4),
    .READ_LAT (1)
  ) u_lat1 (
    .clk      (clk),
    .reset    (reset),
    .ADDRESS  (ADDRESS),
    .wd       (wd),
    .wmask    (wmask),
    .banksel  (banksel),
    .read     (read),
    .write    (write),
    .dataout  (dout1),
    .rvalid   (rv1),
    .conflict (cf1)
  );

  srambank_array #(
    .WIDTH    (16),
    .DEPTH    (128),
    .NBANKS   (4),
    .LANE     (4),
    .READ_LAT (2)
  ) u_lat2 (
    .clk      (clk),
    .reset    (reset),
    .ADDRESS  (ADDRESS),
    .wd       (wd),
    .wmask    (wmask),
    .banksel  (banksel),
    .read     (read),
    .write    (write),
    .dataout  (dout2),
    .rvalid   (rv2),
    .conflict (cf2)
  );

  // Reference model: flat word array plus a queue of reads with delivery cycle.
  typedef struct {
    logic [15:0] data;
    int unsigned due;
  } rd_t;

  logic [15:0] mem_m [512];
  rd_t         pend1[$];
  rd_t         pend2[$];
  logic [15:0] exp_d1 = '0, exp_d2 = '0;
  logic        exp_rv1 = 1'b0, exp_rv2 = 1'b0, exp_cf = 1'b0;
  int unsigned cyc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    check("dout_lat1", 32'(dout1), 32'(exp_d1));
    check("rv_lat1",   32'(rv1),   32'(exp_rv1));
    check("cf_lat1",   32'(cf1),   32'(exp_cf));
    check("dout_lat2", 32'(dout2), 32'(exp_d2));
    check("rv_lat2",   32'(rv2),   32'(exp_rv2));
    check("cf_lat2",   32'(cf2),   32'(exp_cf));
  endtask

  // One clock edge with the currently driven inputs, then model update and check.
  task automatic cycle();
    logic        is_w, is_r, is_c;
    logic [15:0] word;
    @(posedge clk);
    cyc++;
    is_w = banksel && write;
    is_r = banksel && read && !write;
    is_c = banksel && read && write;
    if (is_r) begin
      pend1.push_back('{data: mem_m[ADDRESS], due: cyc});
      pend2.push_back('{data: mem_m[ADDRESS], due: cyc + 1});
    end
    if (is_w) begin
      word = mem_m[ADDRESS];
      for (int i = 0; i < NL; i++) begin
        if (wmask[i]) word[i*LANE +: LANE] = wd[i*LANE +: LANE];
      end
      mem_m[ADDRESS] = word;
    end
    exp_cf  = is_c;
    exp_rv1 = 1'b0;
    if (pend1.size() > 0 && pend1[0].due == cyc) begin
      exp_rv1 = 1'b1;
      exp_d1  = pend1[0].data;
      void'(pend1.pop_front());
    end
    exp_rv2 = 1'b0;
    if (pend2.size() > 0 && pend2[0].due == cyc) begin
      exp_rv2 = 1'b1;
      exp_d2  = pend2[0].data;
      void'(pend2.pop_front());
    end
    #1;
    check_outputs();
  endtask

  task automatic op(input logic bs, input logic r, input logic w,
                    input logic [8:0] a, input logic [15:0] d, input logic [3:0] m);
    banksel = bs;
    read    = r;
    write   = w;
    ADDRESS = a;
    wd      = d;
    wmask   = m;
    cycle();
  endtask

  task automatic idle();
    op(1'b0, 1'b0, 1'b0, 9'h000, 16'h0000, 4'h0);
  endtask

  // Reset asserted mid-cycle: outputs must clear without waiting for an edge.
  task automatic do_reset();
    banksel = 1'b0;
    read    = 1'b0;
    write   = 1'b0;
    reset   = 1'b1;
    #1;
    pend1.delete();
    pend2.delete();
    exp_d1  = '0;
    exp_d2  = '0;
    exp_rv1 = 1'b0;
    exp_rv2 = 1'b0;
    exp_cf  = 1'b0;
    check_outputs();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #200000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [8:0] sweep [4];
    sweep[0] = 9'h000;
    sweep[1] = 9'h080;
    sweep[2] = 9'h100;
    sweep[3] = 9'h1FF;

    #2;
    do_reset();
    repeat (10) idle();

    // Give every location a known value so later reads are never X.
    for (int a = 0; a < 512; a++) op(1'b1, 1'b0, 1'b1, 9'(a), 16'($urandom), 4'hF);
    idle();

    // Lane-masked write.
    op(1'b1, 1'b0, 1'b1, 9'h000, 16'hFFFF, 4'hF);
    op(1'b1, 1'b0, 1'b1, 9'h000, 16'h1234, 4'b0101);
    op(1'b1, 1'b1, 1'b0, 9'h000, 16'h0000, 4'h0);
    check("mask_rd_lat1", 32'(dout1), 32'h0000F2F4);
    check("mask_rv_lat1", 32'(rv1), 32'd1);
    check("mask_rv0_lat2", 32'(rv2), 32'd0);
    idle();
    check("mask_rd_lat2", 32'(dout2), 32'h0000F2F4);
    check("mask_rv_lat2", 32'(rv2), 32'd1);
    check("mask_rv1_done", 32'(rv1), 32'd0);

    // Masked write with no lanes still blocks the read.
    op(1'b1, 1'b1, 1'b1, 9'h000, 16'h0000, 4'h0);
    idle();
    op(1'b1, 1'b1, 1'b0, 9'h000, 16'h0000, 4'h0);
    check("zmask_keep", 32'(dout1), 32'h0000F2F4);
    idle();

    // Bank sweep, back-to-back reads across all banks.
    for (int k = 0; k < 4; k++) op(1'b1, 1'b0, 1'b1, sweep[k], 16'(sweep[k]), 4'hF);
    for (int k = 0; k < 4; k++) begin
      op(1'b1, 1'b1, 1'b0, sweep[k], 16'h0000, 4'h0);
      check("sweep_lat1", 32'(dout1), 32'(sweep[k]));
      check("sweep_rv_lat1", 32'(rv1), 32'd1);
      if (k > 0) begin
        check("sweep_lat2", 32'(dout2), 32'(sweep[k-1]));
        check("sweep_rv_lat2", 32'(rv2), 32'd1);
      end
    end
    idle();
    check("sweep_lat2_last", 32'(dout2), 32'(sweep[3]));
    check("sweep_rv1_end", 32'(rv1), 32'd0);
    idle();
    check("sweep_rv2_end", 32'(rv2), 32'd0);

    // Read/write conflict.
    op(1'b1, 1'b0, 1'b1, 9'h005, 16'hAAAA, 4'hF);
    op(1'b1, 1'b1, 1'b0, 9'h005, 16'h0000, 4'h0);
    op(1'b1, 1'b1, 1'b1, 9'h005, 16'h5555, 4'hF);
    check("conf_flag", 32'(cf1), 32'd1);
    check("conf_hold", 32'(dout1), 32'h0000AAAA);
    check("conf_norv", 32'(rv1), 32'd0);
    idle();
    check("conf_clear", 32'(cf1), 32'd0);
    op(1'b1, 1'b1, 1'b0, 9'h005, 16'h0000, 4'h0);
    check("conf_newdata", 32'(dout1), 32'h00005555);

    // banksel low: read and write ignored.
    op(1'b0, 1'b1, 1'b1, 9'h005, 16'h0F0F, 4'hF);
    check("nosel_rv", 32'(rv1), 32'd0);
    idle();
    op(1'b1, 1'b1, 1'b0, 9'h005, 16'h0000, 4'h0);
    check("nosel_old", 32'(dout1), 32'h00005555);
    idle();

    // Write during an in-flight latency-2 read does not disturb it.
    op(1'b1, 1'b1, 1'b0, 9'h005, 16'h0000, 4'h0);
    op(1'b1, 1'b0, 1'b1, 9'h005, 16'h1111, 4'hF);
    check("inflight_lat2", 32'(dout2), 32'h00005555);

    // Reset one cycle after a latency-2 read.
    op(1'b1, 1'b1, 1'b0, 9'h005, 16'h0000, 4'h0);
    do_reset();
    idle();
    check("rst_rv_lat2", 32'(rv2), 32'd0);
    check("rst_dout_lat2", 32'(dout2), 32'd0);

    // Randomised traffic with occasional resets.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      op(($urandom_range(0, 7) != 0), 1'($urandom), 1'($urandom),
         9'($urandom), 16'($urandom), 4'($urandom));
    end
    idle();
    idle();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
